// File: rtl/windowed_regfile_if.sv
// Bus bundle for windowed_regfile: window control, two read ports, one write port and status.
interface windowed_regfile_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned WIN_W  = 2
);
    logic              win_ld;
    logic [WIN_W-1:0]  win_in;
    logic              win_inc;
    logic              win_dec;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [WIN_W-1:0]  win_out;
    logic              ovf;
    logic              unf;

    modport master (
        output win_ld, win_in, win_inc, win_dec,
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
        input  rd_data1, rd_data2, win_out, ovf, unf
    );

    modport slave (
        input  win_ld, win_in, win_inc, win_dec,
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
        output rd_data1, rd_data2, win_out, ovf, unf
    );
endinterface

// File: rtl/windowed_regfile.sv
// Windowed register file: NUM_WIN banks selected by a saturating window pointer, r0 hardwired to zero.
// Optional same-cycle write-to-read forwarding with WINDOWED_REGFILE_BYPASS_EN.
module windowed_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned WIN_W  = 2
) (
    input logic clk,
    input logic rst,
    windowed_regfile_if.slave bus
);
    localparam int unsigned NUM_WIN = 1 << WIN_W;
    localparam int unsigned DEPTH   = 1 << (WIN_W + ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [WIN_W-1:0]  cwp_q, cwp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_ok;
    logic [DATA_W-1:0] stored1, stored2;

    assign wr_ok = bus.wr_en && (bus.wr_addr != '0);

    // Pointer/flag next state: load beats inc/dec; simultaneous inc+dec is a no-op
    always_comb begin
        cwp_d = cwp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.win_ld) begin
            cwp_d = bus.win_in;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (bus.win_inc && !bus.win_dec) begin
            if (cwp_q == WIN_W'(NUM_WIN - 1))
                ovf_d = 1'b1;
            else
                cwp_d = cwp_q + WIN_W'(1);
        end else if (bus.win_dec && !bus.win_inc) begin
            if (cwp_q == '0)
                unf_d = 1'b1;
            else
                cwp_d = cwp_q - WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cwp_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Writes use the pre-update pointer, so a write racing a window change lands in the old bank
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[{cwp_q, bus.wr_addr}] <= bus.wr_data;
        end
    end

    assign stored1 = (bus.rd_addr1 == '0) ? '0 : mem[{cwp_q, bus.rd_addr1}];
    assign stored2 = (bus.rd_addr2 == '0) ? '0 : mem[{cwp_q, bus.rd_addr2}];

`ifdef WINDOWED_REGFILE_BYPASS_EN
    assign bus.rd_data1 = (wr_ok && (bus.rd_addr1 == bus.wr_addr)) ? bus.wr_data : stored1;
    assign bus.rd_data2 = (wr_ok && (bus.rd_addr2 == bus.wr_addr)) ? bus.wr_data : stored2;
`else
    assign bus.rd_data1 = stored1;
    assign bus.rd_data2 = stored2;
`endif

    assign bus.win_out = cwp_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
endmodule

// File: tb/tb_windowed_regfile.sv
// Directed self-checking bench for windowed_regfile (default parameters).
module tb_windowed_regfile;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned WIN_W  = 2;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    windowed_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN_W(WIN_W)) bus ();

    windowed_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN_W(WIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        bus.win_ld  = 1'b0;
        bus.win_inc = 1'b0;
        bus.win_dec = 1'b0;
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.win_in   = '0;
        bus.rd_addr1 = 3'd3;
        bus.rd_addr2 = 3'd0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        idle();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_win", 32'(bus.win_out), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_unf", 32'(bus.unf), 32'd0);
        chk("rst_r3", 32'(bus.rd_data1), 32'h0);

        // r3 = 0x1234 in window 0
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'h1234;
        #1;
`ifdef WINDOWED_REGFILE_BYPASS_EN
        chk("same_cycle_r3", 32'(bus.rd_data1), 32'h1234);
`else
        chk("same_cycle_r3", 32'(bus.rd_data1), 32'h0);
`endif
        tick();
        idle();
        #1;
        chk("w0_r3", 32'(bus.rd_data1), 32'h1234);
        chk("w0_r0", 32'(bus.rd_data2), 32'h0);

        // Write 0xAAAA on the same edge as win_inc: must land in window 0
        bus.wr_en = 1'b1; bus.wr_data = 16'hAAAA; bus.win_inc = 1'b1;
        tick();
        idle();
        #1;
        chk("inc_win1", 32'(bus.win_out), 32'd1);
        chk("w1_r3_empty", 32'(bus.rd_data1), 32'h0);
        bus.wr_en = 1'b1; bus.wr_data = 16'h5555;
        tick();
        idle();
        #1;
        chk("w1_r3", 32'(bus.rd_data1), 32'h5555);
        bus.win_dec = 1'b1;
        tick();
        idle();
        #1;
        chk("dec_win0", 32'(bus.win_out), 32'd0);
        chk("w0_r3_old", 32'(bus.rd_data1), 32'hAAAA);

        // Climb to the top window, then overflow
        bus.win_inc = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("top_win3", 32'(bus.win_out), 32'd3);
        chk("top_ovf0", 32'(bus.ovf), 32'd0);
        tick();
        idle();
        #1;
        chk("sat_win3", 32'(bus.win_out), 32'd3);
        chk("sat_ovf1", 32'(bus.ovf), 32'd1);
        bus.win_inc = 1'b1; bus.win_dec = 1'b1;
        tick();
        idle();
        #1;
        chk("both_win3", 32'(bus.win_out), 32'd3);
        chk("both_ovf1", 32'(bus.ovf), 32'd1);
        // Load wins over a concurrent inc and clears ovf
        bus.win_ld = 1'b1; bus.win_in = 2'd2; bus.win_inc = 1'b1;
        tick();
        idle();
        #1;
        chk("ld_win2", 32'(bus.win_out), 32'd2);
        chk("ld_ovf0", 32'(bus.ovf), 32'd0);

        // Underflow from window 0
        bus.win_ld = 1'b1; bus.win_in = 2'd0;
        tick();
        idle();
        bus.win_dec = 1'b1;
        tick();
        idle();
        #1;
        chk("unf_win0", 32'(bus.win_out), 32'd0);
        chk("unf_set", 32'(bus.unf), 32'd1);
        bus.win_inc = 1'b1; bus.win_dec = 1'b1;
        tick();
        idle();
        #1;
        chk("both_win0", 32'(bus.win_out), 32'd0);
        chk("both_unf1", 32'(bus.unf), 32'd1);
        bus.win_inc = 1'b1;
        tick();
        idle();
        #1;
        chk("sticky_win1", 32'(bus.win_out), 32'd1);
        chk("sticky_unf", 32'(bus.unf), 32'd1);
        bus.win_dec = 1'b1;
        tick();
        idle();

        // Same-cycle write/read on r5 of window 0
        bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 16'h1111;
        tick();
        bus.wr_data = 16'hBEEF; bus.rd_addr1 = 3'd5; bus.rd_addr2 = 3'd5;
        #1;
`ifdef WINDOWED_REGFILE_BYPASS_EN
        chk("byp_rd1", 32'(bus.rd_data1), 32'hBEEF);
        chk("byp_rd2", 32'(bus.rd_data2), 32'hBEEF);
`else
        chk("byp_rd1", 32'(bus.rd_data1), 32'h1111);
        chk("byp_rd2", 32'(bus.rd_data2), 32'h1111);
`endif
        tick();
        idle();
        #1;
        chk("r5_after", 32'(bus.rd_data1), 32'hBEEF);

        // r0 discards writes, including the forwarding path
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'hFFFF; bus.rd_addr1 = 3'd0;
        #1;
        chk("r0_same", 32'(bus.rd_data1), 32'h0);
        tick();
        idle();
        #1;
        chk("r0_after", 32'(bus.rd_data1), 32'h0);

        // Reset overrides a concurrent write and inc
        bus.win_ld = 1'b1; bus.win_in = 2'd2;
        tick();
        idle();
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'h7777; bus.win_inc = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rst2_win", 32'(bus.win_out), 32'd0);
        chk("rst2_ovf", 32'(bus.ovf), 32'd0);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr1 = 3'(a);
            #1;
            chk($sformatf("rst2_w0_r%0d", a), 32'(bus.rd_data1), 32'h0);
        end
        bus.win_inc = 1'b1;
        tick();
        idle();
        bus.rd_addr1 = 3'd3;
        #1;
        chk("rst2_w1_r3", 32'(bus.rd_data1), 32'h0);
        bus.win_ld = 1'b1; bus.win_in = 2'd2;
        tick();
        idle();
        #1;
        chk("rst2_w2_r3", 32'(bus.rd_data1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
